snake_engine: RTL and testbench

- Owns snake state for the Snake display path: cell occupancy, head/tail ring buffer, direction, growth and collision.
- Answers per-pixel "is this pixel snake, and what colour" queries from the VGA timing generator's `x`/`y`/`vde`.
- Its registered `snake_on`/`snake_color`/`vde_out` drive the combinational pixel generator directly.
- Advances one cell per `step` pulse from the game-tick divider.

---
 rtl/snake_engine.sv | 147 ++++++++++++++
 tb/tb_snake_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_engine.sv
// snake_engine: snake occupancy, segment ring, move FSM and registered pixel render; define SNAKE_WALL_WRAP_EN for wrap-around edges
module snake_engine #(
  parameter int          GRID_W     = 40,
  parameter int          GRID_H     = 30,
  parameter int          CELL_SHIFT = 4,
  parameter int          MAX_LEN    = 32,
  parameter int          START_LEN  = 4,
  parameter logic [23:0] HEAD_COLOR = 24'h00C000,
  parameter logic [23:0] BODY_COLOR = 24'h006000,
  parameter logic [23:0] DEAD_COLOR = 24'hC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        vde,
  input  logic        step,
  input  logic [1:0]  dir,
  input  logic        dir_valid,
  input  logic        grow,
  output logic        snake_on,
  output logic [23:0] snake_color,
  output logic        vde_out,
  output logic [5:0]  head_x,
  output logic [4:0]  head_y,
  output logic [5:0]  length,
  output logic        busy,
  output logic        collision
);
  localparam int CELLS = GRID_W * GRID_H;
  localparam int IW = $clog2(CELLS);
  localparam int PW = $clog2(MAX_LEN);
  localparam logic [5:0] HX0 = 6'(GRID_W / 2);
  localparam logic [4:0] HY0 = 5'(GRID_H / 2);
  typedef enum logic [2:0] {IDLE, CALC, CHECK, WRITE, DEAD} state_t;
  state_t state, state_nx;
  logic [CELLS-1:0] occ;
  logic [5:0] ring_x [MAX_LEN];
  logic [4:0] ring_y [MAX_LEN];
  logic [PW-1:0] head_ptr, tail_ptr;
  logic [1:0] cur_dir, next_dir;
  logic grow_pend, grow_eff, dir_ok, wall, hit, pix_on, is_head;
  logic [5:0] cand_x, nx;
  logic [4:0] cand_y, ny;
  logic [5:0] tail_x;
  logic [4:0] tail_y;
  logic [9:0] cx, cy;

  function automatic logic [IW-1:0] cell_idx(input logic [9:0] c, input logic [9:0] r);
    return IW'(32'(r) * GRID_W + 32'(c));
  endfunction

  assign tail_x = ring_x[tail_ptr];
  assign tail_y = ring_y[tail_ptr];
  assign grow_eff = grow_pend && length < 6'(MAX_LEN);
  assign dir_ok = dir_valid && dir != (cur_dir ^ 2'd2);
  assign nx = cur_dir == 2'd0 ? (head_x == 6'(GRID_W - 1) ? 6'd0 : head_x + 6'd1)
            : cur_dir == 2'd2 ? (head_x == 6'd0 ? 6'(GRID_W - 1) : head_x - 6'd1) : head_x;
  assign ny = cur_dir == 2'd1 ? (head_y == 5'(GRID_H - 1) ? 5'd0 : head_y + 5'd1)
            : cur_dir == 2'd3 ? (head_y == 5'd0 ? 5'(GRID_H - 1) : head_y - 5'd1) : head_y;
`ifdef SNAKE_WALL_WRAP_EN
  assign wall = 1'b0;
`else
  assign wall = (cur_dir == 2'd0 && head_x == 6'(GRID_W - 1)) || (cur_dir == 2'd2 && head_x == 6'd0)
             || (cur_dir == 2'd1 && head_y == 5'(GRID_H - 1)) || (cur_dir == 2'd3 && head_y == 5'd0);
`endif
  // the tail cell is free to enter when it is about to vacate (no growth this move)
  assign hit = occ[cell_idx(10'(cand_x), 10'(cand_y))]
            && !(cand_x == tail_x && cand_y == tail_y && !grow_eff);
  assign busy = state != IDLE;
  assign collision = state == DEAD;
  assign cx = x >> CELL_SHIFT;
  assign cy = y >> CELL_SHIFT;
  assign pix_on = vde && cx < 10'(GRID_W) && cy < 10'(GRID_H) && occ[cell_idx(cx, cy)];
  assign is_head = cx == 10'(head_x) && cy == 10'(head_y);

  // move FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end

  // move FSM next state; DEAD is left only through reset
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (step ? CALC : IDLE)
             : state == CALC  ? (wall ? DEAD : CHECK)
             : state == CHECK ? (hit ? DEAD : WRITE)
             : state == WRITE ? IDLE : DEAD;
  end

  // snake state: bitmap, body ring (head kept outside the ring), direction and growth
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ <= '0;
      for (int i = 0; i <= START_LEN; i++) occ[cell_idx(10'(HX0 - 6'(i)), 10'(HY0))] <= 1'b1;
      for (int i = 0; i < MAX_LEN; i++) begin
        ring_x[i] <= i < START_LEN ? HX0 - 6'(START_LEN - i) : 6'd0;
        ring_y[i] <= i < START_LEN ? HY0 : 5'd0;
      end
      head_ptr <= PW'(START_LEN);
      tail_ptr <= '0;
      head_x <= HX0;
      head_y <= HY0;
      length <= 6'(START_LEN);
      cur_dir <= 2'd0;
      next_dir <= 2'd0;
      grow_pend <= 1'b0;
      cand_x <= 6'd0;
      cand_y <= 5'd0;
    end else begin
      if (state != DEAD && dir_ok) next_dir <= dir;
      if (state == IDLE && step) cur_dir <= dir_ok ? dir : next_dir;
      if (state == CALC) begin
        cand_x <= nx;
        cand_y <= ny;
      end
      if (state == WRITE) begin
        if (!grow_eff) begin
          occ[cell_idx(10'(tail_x), 10'(tail_y))] <= 1'b0;
          tail_ptr <= tail_ptr == PW'(MAX_LEN - 1) ? '0 : tail_ptr + 1'b1;
        end else length <= length + 6'd1;
        occ[cell_idx(10'(cand_x), 10'(cand_y))] <= 1'b1;
        ring_x[head_ptr] <= head_x;
        ring_y[head_ptr] <= head_y;
        head_ptr <= head_ptr == PW'(MAX_LEN - 1) ? '0 : head_ptr + 1'b1;
        head_x <= cand_x;
        head_y <= cand_y;
        grow_pend <= 1'b0;
      end
      if (state != DEAD && grow) grow_pend <= 1'b1;
    end
  end

  // registered pixel lookup, one cycle behind x/y/vde
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snake_on <= 1'b0;
      snake_color <= 24'd0;
      vde_out <= 1'b0;
    end else begin
      snake_on <= pix_on;
      vde_out <= vde;
      snake_color <= !pix_on ? 24'd0 : state == DEAD ? DEAD_COLOR : is_head ? HEAD_COLOR : BODY_COLOR;
    end
  end
endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine: randomized and directed checks of snake_engine against a cell-list model
module tb_snake_engine;
  logic clk = 1'b0, rst_n = 1'b0, vde = 1'b0, step = 1'b0, dir_valid = 1'b0, grow = 1'b0;
  logic [9:0] x = 10'd0, y = 10'd0;
  logic [1:0] dir = 2'd0;
  logic snake_on, vde_out, busy, collision;
  logic [23:0] snake_color;
  logic [5:0] head_x, length;
  logic [4:0] head_y;
  int n_checks = 0, n_err = 0;
  int qx[$], qy[$];
  int m_cur, m_next;
  bit m_dead, m_gp;

  always #5 clk = ~clk;

  snake_engine dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .vde(vde), .step(step), .dir(dir),
    .dir_valid(dir_valid), .grow(grow), .snake_on(snake_on), .snake_color(snake_color),
    .vde_out(vde_out), .head_x(head_x), .head_y(head_y), .length(length), .busy(busy),
    .collision(collision)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit occupied(input int c, input int r);
    foreach (qx[i]) if (qx[i] == c && qy[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    qx.delete();
    qy.delete();
    for (int i = 0; i <= 4; i++) begin
      qx.push_back(20 - i);
      qy.push_back(15);
    end
    m_cur = 0;
    m_next = 0;
    m_dead = 1'b0;
    m_gp = 1'b0;
  endtask

  task automatic model_step(input int d, input bit dv, input bit g);
    int nx, ny;
    bit gn, hit;
    if (m_dead) return;
    if (g) m_gp = 1'b1;
    if (dv && d != (m_cur ^ 2)) m_next = d;
    m_cur = m_next;
    nx = qx[0] + (m_cur == 0 ? 1 : 0) - (m_cur == 2 ? 1 : 0);
    ny = qy[0] + (m_cur == 1 ? 1 : 0) - (m_cur == 3 ? 1 : 0);
`ifdef SNAKE_WALL_WRAP_EN
    nx = (nx + 40) % 40;
    ny = (ny + 30) % 30;
`else
    if (nx < 0 || nx >= 40 || ny < 0 || ny >= 30) begin
      m_dead = 1'b1;
      return;
    end
`endif
    gn = m_gp && (qx.size() - 1 < 32);
    hit = occupied(nx, ny) && !(!gn && nx == qx[qx.size() - 1] && ny == qy[qy.size() - 1]);
    if (hit) begin
      m_dead = 1'b1;
      return;
    end
    qx.push_front(nx);
    qy.push_front(ny);
    if (!gn) begin
      void'(qx.pop_back());
      void'(qy.pop_back());
    end
    m_gp = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    step = 1'b0;
    grow = 1'b0;
    dir_valid = 1'b0;
    vde = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_hx"}, 32'(head_x), 20);
    check({tag, "_hy"}, 32'(head_y), 15);
    check({tag, "_len"}, 32'(length), 4);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_coll"}, 32'(collision), 0);
    check({tag, "_on"}, 32'(snake_on), 0);
    check({tag, "_col"}, 32'(snake_color), 0);
    check({tag, "_vde"}, 32'(vde_out), 0);
  endtask

  task automatic move(input int d, input bit dv, input bit g);
    bit was_dead;
    was_dead = m_dead;
    step = 1'b1;
    dir = 2'(d);
    dir_valid = dv;
    grow = g;
    model_step(d, dv, g);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      step = 1'b0;
      dir_valid = 1'b0;
      grow = 1'b0;
      check("busy_mid", 32'(busy), 1);
      if (k == 1) check("coll_n1", 32'(collision), 32'(was_dead));
      if (k == 3) check("coll_n3", 32'(collision), 32'(m_dead));
    end
    @(negedge clk);
    check("head_x", 32'(head_x), qx[0]);
    check("head_y", 32'(head_y), qy[0]);
    check("length", 32'(length), qx.size() - 1);
    check("busy_end", 32'(busy), 32'(m_dead));
    check("coll_end", 32'(collision), 32'(m_dead));
  endtask

  task automatic set_dir(input int d);
    dir = 2'(d);
    dir_valid = 1'b1;
    if (!m_dead && d != (m_cur ^ 2)) m_next = d;
    @(negedge clk);
    dir_valid = 1'b0;
  endtask

  task automatic probe(input int px, input int py, input bit v);
    int c, r;
    bit on;
    logic [23:0] col;
    x = 10'(px);
    y = 10'(py);
    vde = v;
    @(negedge clk);
    c = px >> 4;
    r = py >> 4;
    on = v && c < 40 && r < 30 && occupied(c, r);
    col = !on ? 24'h0 : m_dead ? 24'hC00000 : (c == qx[0] && r == qy[0]) ? 24'h00C000 : 24'h006000;
    check("snake_on", 32'(snake_on), 32'(on));
    check("snake_color", 32'(snake_color), 32'(col));
    check("vde_out", 32'(vde_out), 32'(v));
    vde = 1'b0;
  endtask

  task automatic probe_seg();
    int i;
    i = $urandom_range(qx.size() - 1);
    probe(qx[i] * 16 + $urandom_range(15), qy[i] * 16 + $urandom_range(15), 1'b1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    check_reset("reset");
    probe(320, 240, 1'b1);
    check("head_pix_color", 32'(snake_color), 32'h00C000);
    probe(256, 240, 1'b1);
    check("body_pix_color", 32'(snake_color), 32'h006000);
    probe(0, 0, 1'b1);
    check("origin_off", 32'(snake_on), 0);
    move(0, 1'b0, 1'b0);
    check("step_head_x", 32'(head_x), 21);
    check("step_len", 32'(length), 4);
    probe(260, 245, 1'b1);
    check("tail_cleared", 32'(snake_on), 0);

    do_reset();
    move(0, 1'b0, 1'b1);
    check("grow_len", 32'(length), 5);
    probe(256, 240, 1'b1);
    check("grow_tail_kept", 32'(snake_on), 1);
    move(2, 1'b1, 1'b0);
    check("reverse_ignored", 32'(head_x), 22);

    do_reset();
    move(0, 1'b0, 1'b1);
    move(1, 1'b1, 1'b0);
    move(2, 1'b1, 1'b0);
    move(2, 1'b1, 1'b0);
    move(3, 1'b1, 1'b0);
    move(0, 1'b1, 1'b0);
    move(0, 1'b0, 1'b0);
    check("chase_no_coll", 32'(collision), 0);
    probe_seg();

    do_reset();
    move(0, 1'b0, 1'b1);
    move(1, 1'b1, 1'b0);
    move(2, 1'b1, 1'b0);
    move(3, 1'b1, 1'b0);
    check("self_coll", 32'(collision), 1);
    move(0, 1'b0, 1'b1);
    check("dead_len", 32'(length), 5);
    probe(qx[0] * 16 + 7, qy[0] * 16 + 7, 1'b1);
    check("dead_color", 32'(snake_color), 32'hC00000);

    do_reset();
    set_dir(1);
    set_dir(2);
    move(0, 1'b0, 1'b0);
    check("dir_down_y", 32'(head_y), 16);
    check("dir_down_x", 32'(head_x), 20);

    do_reset();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_reset("midmove_rst");

    do_reset();
    for (int i = 0; i < 19; i++) move(0, 1'b0, 1'b0);
    check("edge_x", 32'(head_x), 39);
    move(0, 1'b0, 1'b0);
`ifdef SNAKE_WALL_WRAP_EN
    check("wrap_x", 32'(head_x), 0);
    check("wrap_coll", 32'(collision), 0);
`else
    check("wall_coll", 32'(collision), 1);
    check("wall_x", 32'(head_x), 39);
`endif

    do_reset();
    for (int i = 0; i < 18; i++) move(0, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) move(1, 1'b1, 1'b1);
    check("max_len", 32'(length), 32);
    probe_seg();

    for (int ep = 0; ep < 12; ep++) begin
      do_reset();
      for (int s = 0; s < 50 && !m_dead; s++) begin
        move(int'($urandom_range(3)), 1'($urandom_range(1)), $urandom_range(3) == 0);
        probe(int'($urandom_range(1023)), int'($urandom_range(1023)), 1'($urandom_range(1)));
        probe_seg();
      end
      probe_seg();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
